// File: rtl/sdf_query_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, fully pipelined SDF unit among NUM_REQ cores.
// Results return to the issuing core through a tag shift register aligned with the unit latency.
module sdf_query_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int SDF_LATENCY = 3,
   parameter int FP_W        = 16
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic [NUM_REQ-1:0]                req_valid_in,
   input  logic [NUM_REQ-1:0][3*FP_W-1:0]    req_point_in,
   output logic [NUM_REQ-1:0]                req_ready_out,
   output logic [NUM_REQ-1:0]                resp_valid_out,
   output logic [FP_W-1:0]                   resp_sdf_out,
   output logic [3*FP_W-1:0]                 sdf_point_out,
   output logic                              sdf_valid_out,
   input  logic [FP_W-1:0]                   sdf_dist_in,
   input  logic                              sdf_valid_in,
   output logic [31:0]                       issue_count_out,
   output logic                              err_out
);

   localparam int TAG_W = $clog2(NUM_REQ);

   // Handshake: a query transfers on the edge where req_valid_in[i] and
   // req_ready_out[i] are both high; req_ready_out is one-hot or zero.

   logic [TAG_W-1:0]                  r_rr_ptr;
   logic [NUM_REQ-1:0]                r_outstanding;
   logic [TAG_W-1:0]                  r_issue_tag;
   logic                              r_sdf_valid;
   logic [3*FP_W-1:0]                 r_sdf_point;
   logic [SDF_LATENCY-1:0]            r_pipe_v;
   logic [SDF_LATENCY-1:0][TAG_W-1:0] r_pipe_tag;
   logic [NUM_REQ-1:0]                r_resp_valid;
   logic [FP_W-1:0]                   r_resp_sdf;
   logic [31:0]                       r_issue_count;
   logic                              r_err;

   logic [NUM_REQ-1:0]                w_eligible;
   logic [NUM_REQ-1:0]                w_grant;
   logic [TAG_W-1:0]                  w_grant_idx;
   logic                              w_grant_any;
   logic [TAG_W-1:0]                  w_rr_next;
   logic                              w_head_v;
   logic [TAG_W-1:0]                  w_head_tag;
   logic                              w_resp;
   logic                              w_err;
   logic [NUM_REQ-1:0]                w_resp_onehot;
   logic [NUM_REQ-1:0]                w_out_next;

   assign w_eligible = req_valid_in & ~r_outstanding;

   // Scan starts at r_rr_ptr and wraps; first eligible core wins.
   always_comb begin
      int scan_idx;
      w_grant     = '0;
      w_grant_idx = '0;
      w_grant_any = 1'b0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(r_rr_ptr) + k;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!w_grant_any && w_eligible[scan_idx]) begin
            w_grant_any = 1'b1;
            w_grant_idx = TAG_W'(scan_idx);
         end
      end
      if (w_grant_any) w_grant[w_grant_idx] = 1'b1;
   end

   assign w_rr_next = (w_grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

   assign w_head_v      = r_pipe_v[SDF_LATENCY-1];
   assign w_head_tag    = r_pipe_tag[SDF_LATENCY-1];
   assign w_resp        = sdf_valid_in & w_head_v;
   assign w_err         = sdf_valid_in ^ w_head_v;
   assign w_resp_onehot = NUM_REQ'(1) << w_head_tag;

   // A response frees its core on the same edge; a missing result leaves it stalled.
   always_comb begin
      w_out_next = r_outstanding;
      if (w_resp) w_out_next[w_head_tag] = 1'b0;
      if (w_grant_any) w_out_next[w_grant_idx] = 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rr_ptr      <= '0;
         r_outstanding <= '0;
         r_issue_tag   <= '0;
         r_sdf_valid   <= 1'b0;
         r_sdf_point   <= '0;
         r_issue_count <= '0;
      end else begin
         r_sdf_valid   <= w_grant_any;
         r_outstanding <= w_out_next;
         if (w_grant_any) begin
            r_sdf_point   <= req_point_in[w_grant_idx];
            r_issue_tag   <= w_grant_idx;
            r_rr_ptr      <= w_rr_next;
            r_issue_count <= r_issue_count + 32'd1;
         end
      end
   end

   // Stage 0 follows the issue register, so the head lines up with sdf_valid_in.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_pipe_v   <= '0;
         r_pipe_tag <= '0;
      end else begin
         r_pipe_v[0]   <= r_sdf_valid;
         r_pipe_tag[0] <= r_issue_tag;
         for (int k = 1; k < SDF_LATENCY; k++) begin
            r_pipe_v[k]   <= r_pipe_v[k-1];
            r_pipe_tag[k] <= r_pipe_tag[k-1];
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_resp_valid <= '0;
         r_resp_sdf   <= '0;
         r_err        <= 1'b0;
      end else begin
         r_resp_valid <= w_resp ? w_resp_onehot : '0;
         if (w_resp) r_resp_sdf <= sdf_dist_in;
         if (w_err) r_err <= 1'b1;
      end
   end

   assign req_ready_out   = w_grant;
   assign resp_valid_out  = r_resp_valid;
   assign resp_sdf_out    = r_resp_sdf;
   assign sdf_point_out   = r_sdf_point;
   assign sdf_valid_out   = r_sdf_valid;
   assign issue_count_out = r_issue_count;
   assign err_out         = r_err;

endmodule

// File: tb/tb_sdf_query_arbiter.sv
// Randomized bench for sdf_query_arbiter with an SDF-unit responder and a time-based reference model.
module tb_sdf_query_arbiter;

   localparam int N    = 4;
   localparam int L    = 3;
   localparam int FP_W = 16;

   logic                       clk_in = 1'b0;
   logic                       rst_in;
   logic [N-1:0]               req_valid_in;
   logic [N-1:0][3*FP_W-1:0]   req_point_in;
   logic [N-1:0]               req_ready_out;
   logic [N-1:0]               resp_valid_out;
   logic [FP_W-1:0]            resp_sdf_out;
   logic [3*FP_W-1:0]          sdf_point_out;
   logic                       sdf_valid_out;
   logic [FP_W-1:0]            sdf_dist_in;
   logic                       sdf_valid_in;
   logic [31:0]                issue_count_out;
   logic                       err_out;

   sdf_query_arbiter #(.NUM_REQ(N), .SDF_LATENCY(L), .FP_W(FP_W)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .req_valid_in    (req_valid_in),
      .req_point_in    (req_point_in),
      .req_ready_out   (req_ready_out),
      .resp_valid_out  (resp_valid_out),
      .resp_sdf_out    (resp_sdf_out),
      .sdf_point_out   (sdf_point_out),
      .sdf_valid_out   (sdf_valid_out),
      .sdf_dist_in     (sdf_dist_in),
      .sdf_valid_in    (sdf_valid_in),
      .issue_count_out (issue_count_out),
      .err_out         (err_out)
   );

   // clock / reset
   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model: a core is busy until the cycle its result is delivered
   int              m_rr;
   int              m_free_at [N];
   logic [31:0]     m_count;
   logic            m_err;
   logic [47:0]     m_last_pt;

   // scoreboard
   int              iss_cyc_q [$];
   logic [47:0]     iss_pt_q  [$];
   int              rsp_cyc_q [$];
   int              rsp_tag_q [$];
   logic [FP_W-1:0] exp_q     [$];

   // behavioural SDF unit
   int              sdf_due_q  [$];
   logic [FP_W-1:0] sdf_dist_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [FP_W-1:0] sdf_fn(input logic [47:0] p);
      return (p[15:0] + p[31:16] + p[47:32]) ^ 16'h00a5;
   endfunction

   function automatic int model_pick(input logic [N-1:0] rv);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (rv[i] && cyc >= m_free_at[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_rr = 0;
      for (int i = 0; i < N; i++) m_free_at[i] = 0;
      m_count   = '0;
      m_err     = 1'b0;
      m_last_pt = '0;
      iss_cyc_q.delete(); iss_pt_q.delete();
      rsp_cyc_q.delete(); rsp_tag_q.delete(); exp_q.delete();
      sdf_due_q.delete(); sdf_dist_q.delete();
   endtask

   // driver: one clock cycle of stimulus, checking and model update
   task automatic step(input logic [N-1:0] rv, input logic rst_v, input logic spur,
                       input logic fixed_pt, input logic preload);
      int   g;
      logic exp_v;
      logic [47:0] pt;
      @(posedge clk_in);
      cyc++;
      #1;
      rst_in       = rst_v;
      req_valid_in = rv;
      for (int i = 0; i < N; i++)
         req_point_in[i] = fixed_pt ? {16'd3, 16'd2, 16'd1} : {16'($urandom), 32'($urandom)};
      if (rst_v) model_reset();
      sdf_valid_in = 1'b0;
      sdf_dist_in  = 16'($urandom);
      if (!rst_v && sdf_due_q.size() > 0 && sdf_due_q[0] == cyc) begin
         sdf_valid_in = 1'b1;
         sdf_dist_in  = sdf_dist_q.pop_front();
         void'(sdf_due_q.pop_front());
      end else if (spur) begin
         sdf_valid_in = 1'b1;
      end
      if (preload) begin
         dut.r_issue_count <= 32'hFFFF_FFFF;
         m_count = 32'hFFFF_FFFF;
      end
      @(negedge clk_in);
      g = model_pick(rv);
      check("ready", 64'(req_ready_out), (g >= 0) ? (64'd1 << g) : 64'd0);
      exp_v = iss_cyc_q.size() > 0 && iss_cyc_q[0] == cyc;
      check("sdf_valid", 64'(sdf_valid_out), 64'(exp_v));
      if (exp_v) begin
         void'(iss_cyc_q.pop_front());
         m_last_pt = iss_pt_q.pop_front();
      end
      check("sdf_point", 64'(sdf_point_out), 64'(m_last_pt));
      exp_v = rsp_cyc_q.size() > 0 && rsp_cyc_q[0] == cyc;
      check("resp_valid", 64'(resp_valid_out), exp_v ? (64'd1 << rsp_tag_q[0]) : 64'd0);
      if (exp_v) begin
         check("resp_sdf", 64'(resp_sdf_out), 64'(exp_q[0]));
         void'(rsp_cyc_q.pop_front());
         void'(rsp_tag_q.pop_front());
         void'(exp_q.pop_front());
      end
      if (rst_v) check("resp_sdf_rst", 64'(resp_sdf_out), 64'd0);
      check("issue_count", 64'(issue_count_out), 64'(m_count));
      check("err", 64'(err_out), 64'(m_err));
      if (!rst_v && sdf_valid_out) begin
         sdf_due_q.push_back(cyc + L);
         sdf_dist_q.push_back(sdf_fn(sdf_point_out));
      end
      if (!rst_v && g >= 0) begin
         pt = req_point_in[g];
         m_count = m_count + 32'd1;
         m_rr = (g + 1) % N;
         m_free_at[g] = cyc + L + 2;
         iss_cyc_q.push_back(cyc + 1);
         iss_pt_q.push_back(pt);
         rsp_cyc_q.push_back(cyc + L + 2);
         rsp_tag_q.push_back(g);
         exp_q.push_back(sdf_fn(pt));
      end
      if (spur && !rst_v) m_err = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_in       = 1'b1;
      req_valid_in = '0;
      req_point_in = '0;
      sdf_valid_in = 1'b0;
      sdf_dist_in  = '0;
      model_reset();

      repeat (3) step('0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(5);

      // single core 2 with a fixed point
      step(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(8);

      // all cores saturating
      repeat (100) step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(8);

      // core 1 alone, held high while outstanding
      repeat (20) step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(8);

      // random request patterns
      repeat (400) step(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 1'b0);
      idle(8);

      // counter wrap via backdoor preload
      step('0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(8);

      // reset while cores 0 and 3 are in flight
      repeat (2) step(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) step('0, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (12) step(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(8);

      // spurious result with the tag pipeline empty
      step('0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(5);
      repeat (2) step('0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
